aes_round_scheduler: RTL and testbench

- Sequences one shared iterative AES round datapath (subBytes → shiftRows → MixColumns → addRoundKey, plus a final-round bypass of MixColumns) on behalf of NREQ requesters.
- Arbitrates requesters round-robin and owns the 128-bit state register.
- Drives the round-key index into the expanded-key store.
- Returns the ciphertext with the requester ID over a valid/ready output channel.

---
 rtl/aes_round_scheduler.sv | 108 ++++++++++
 tb/tb_aes_round_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_scheduler.sv
// Round-robin front end and state sequencer for one shared
// iterative AES round datapath serving several requesters.
module aes_round_scheduler #(
    parameter int NREQ = 2,
    parameter int NR   = 10,
    parameter int IDW  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_data,
    output logic [127:0]        dp_state,
    output logic                dp_final,
    input  logic [127:0]        dp_next,
    output logic [3:0]          key_idx,
    input  logic [127:0]        rk,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic [IDW-1:0]      out_id,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      fsm;
    logic [127:0]    state_reg;
    logic [3:0]      round;
    logic [IDW-1:0]  rr_ptr;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gid;
    logic [IDW-1:0]  gid_nxt;
    logic [127:0]    win_data;
    logic            found;
    int              idx;
    logic            last;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        grant    = '0;
        gid      = '0;
        win_data = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gid        = IDW'(idx);
                win_data   = req_data[128*idx +: 128];
            end
        end
    end

    assign gid_nxt = (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
    assign last    = (round == 4'(NR));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm       <= IDLE;
            state_reg <= '0;
            round     <= '0;
            rr_ptr    <= '0;
            out_id    <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (found) begin
                        state_reg <= win_data ^ rk;
                        round     <= 4'd1;
                        out_id    <= gid;
                        rr_ptr    <= gid_nxt;
                        fsm       <= ROUND;
                    end
                end
                ROUND: begin
                    state_reg <= dp_next;
                    if (last) begin
                        fsm <= DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Gate with reset so no grant is visible while reset is held.
    assign req_ready = (fsm == IDLE && !reset) ? grant : '0;
    assign busy      = (fsm != IDLE);
    assign out_valid = (fsm == DONE);
    assign out_data  = state_reg;
    assign dp_state  = state_reg;
    assign dp_final  = (fsm == ROUND) && last;
    assign key_idx   = (fsm == ROUND) ? round : 4'd0;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench for aes_round_scheduler with a reference AES-128
// round datapath and key expansion driving dp_next and rk.
module tb_aes_round_scheduler;

    localparam int NREQ = 2;
    localparam int NR   = 10;
    localparam int IDW  = 1;

    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_F = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_F = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_A = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_A = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_B = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_B = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_data;
    logic [127:0]        dp_state;
    logic                dp_final;
    logic [127:0]        dp_next;
    logic [3:0]          key_idx;
    logic [127:0]        rk;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        out_data;
    logic [IDW-1:0]      out_id;
    logic                busy;

    aes_round_scheduler #(.NREQ(NREQ), .NR(NR), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data),
        .dp_state(dp_state), .dp_final(dp_final),
        .dp_next(dp_next), .key_idx(key_idx), .rk(rk),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [127:0]   data;
    } exp_t;

    exp_t         sb[$];
    int           glog[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_out = 0;
    logic [7:0]   sbox[256];
    logic [127:0] rkeys[16];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in,
                                        input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic fin,
                                               input logic [127:0] k);
        logic [7:0]   a[16];
        logic [7:0]   b[16];
        logic [7:0]   c[16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                b[row + 4*col] = a[row + 4*((col + row) % 4)];
        for (int col = 0; col < 4; col++) begin
            x0 = b[4*col]; x1 = b[4*col+1];
            x2 = b[4*col+2]; x3 = b[4*col+3];
            if (fin) begin
                c[4*col] = x0; c[4*col+1] = x1;
                c[4*col+2] = x2; c[4*col+3] = x3;
            end else begin
                c[4*col]   = gmul(x0, 2) ^ gmul(x1, 3) ^ x2 ^ x3;
                c[4*col+1] = x0 ^ gmul(x1, 2) ^ gmul(x2, 3) ^ x3;
                c[4*col+2] = x0 ^ x1 ^ gmul(x2, 2) ^ gmul(x3, 3);
                c[4*col+3] = gmul(x0, 3) ^ x1 ^ x2 ^ gmul(x3, 2);
            end
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = c[i];
        return res ^ k;
    endfunction

    task automatic build_tables();
        logic [7:0]  inv;
        logic [7:0]  q;
        logic [7:0]  rc;
        logic [31:0] w[44];
        logic [31:0] t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            q = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = q;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]],
                     sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rkeys[r] = '0;
        for (int r = 0; r <= NR; r++)
            rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    assign rk = rkeys[key_idx];
    always_comb dp_next = aes_round(dp_state, dp_final, rk);

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL timeout_%s: wait expired, required event absent", name);
    endtask

    task automatic wait_grant(input int g);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (req_valid[g] && req_ready[g]) ok = 1'b1;
        end
        if (!ok) expire("grant");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target);
        for (int i = 0; i < 300 && n_out < target; i++) @(negedge clk);
        if (n_out < target) expire("output");
    endtask

    // Monitor: pop and compare on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got id %0d data %h required none",
                             out_id, out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_id", 128'(out_id), 128'(e.id));
                end
            end
        end
    end

    // Grant logger plus grant/busy and dp_final context checks.
    initial begin
        forever begin
            @(negedge clk);
            if (|req_ready) begin
                check("grant_onehot", 128'($onehot(req_ready)), 128'(1));
                check("grant_not_busy", 128'(busy), 128'(0));
            end
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) glog.push_back(i);
            if (dp_final)
                check("dp_final_ctx", {busy, out_valid, key_idx},
                      {1'b1, 1'b0, 4'd10});
        end
    end

    initial begin
        build_tables();
        reset     = 1'b1;
        out_ready = 1'b1;
        req_data  = {PT_B, PT_A};
        req_valid = 2'b11;
        sb.push_back('{id: 0, data: CT_A});
        sb.push_back('{id: 1, data: CT_B});
        sb.push_back('{id: 0, data: CT_A});
        sb.push_back('{id: 1, data: CT_B});
        #22;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_dp_final", 128'(dp_final), 128'(0));
        check("rst_key_idx", 128'(key_idx), 128'(0));
        check("rst_dp_state", dp_state, 128'(0));
        check("rst_out_id", 128'(out_id), 128'(0));

        // Round-robin with both requesters valid from reset.
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 300 && glog.size() < 4; i++) @(negedge clk);
        if (glog.size() < 4) expire("rr_grants");
        @(posedge clk);
        #1 req_valid = '0;
        wait_out(4);
        check("rr_grant_cnt", 128'(glog.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            if (glog.size() > i)
                check($sformatf("rr_grant%0d", i), 128'(glog[i]), 128'(i % 2));

        // FIPS-197 vector from requester 0 with latency tracking.
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        @(posedge clk);
        #1;
        req_data[127:0] = PT_F;
        req_valid       = 2'b01;
        sb.push_back('{id: 0, data: CT_F});
        wait_grant(0);
        req_valid = '0;
        for (int c = 1; c <= NR; c++) begin
            @(negedge clk);
            check($sformatf("fips_key_idx%0d", c), 128'(key_idx), 128'(c));
            check($sformatf("fips_dp_final%0d", c), 128'(dp_final),
                  128'(c == NR));
            check($sformatf("fips_early_valid%0d", c), 128'(out_valid), 128'(0));
        end
        @(negedge clk);
        check("fips_out_valid", 128'(out_valid), 128'(1));
        wait_out(5);

        // Back-pressure on a block from requester 1.
        @(posedge clk);
        #1;
        out_ready          = 1'b0;
        req_data[255:128]  = PT_F;
        req_valid          = 2'b10;
        sb.push_back('{id: 1, data: CT_F});
        wait_grant(1);
        req_valid = '0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        if (!out_valid) expire("bp_valid");
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", 128'(out_valid), 128'(1));
            check("bp_data", out_data, CT_F);
            check("bp_id", 128'(out_id), 128'(1));
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_after_valid", 128'(out_valid), 128'(0));
        check("bp_after_busy", 128'(busy), 128'(0));
        check("bp_out_count", 128'(n_out), 128'(6));

        // Reset while key_idx=5, then arbitration restarts at requester 0.
        req_data[127:0] = PT_F;
        req_valid       = 2'b01;
        wait_grant(0);
        req_valid = '0;
        for (int i = 0; i < 20 && key_idx != 4'd5; i++) @(negedge clk);
        if (key_idx != 4'd5) expire("key_idx5");
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_key_idx", 128'(key_idx), 128'(0));
        check("mid_rst_dp_state", dp_state, 128'(0));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_dp_final", 128'(dp_final), 128'(0));
        req_data  = {PT_B, PT_A};
        req_valid = 2'b11;
        glog.delete();
        sb.push_back('{id: 0, data: CT_A});
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_grant(0);
        req_valid = '0;
        check("rst_grant_cnt", 128'(glog.size()), 128'(1));
        if (glog.size() > 0)
            check("rst_grant_first", 128'(glog[0]), 128'(0));
        wait_out(7);

        // Idle stability with no requests.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_flags", {busy, out_valid, req_ready}, '0);
            check("idle_state", dp_state, CT_A);
        end

        check("sb_empty", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
